// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, RISC-V
// opcodes handled by the block, FSM state encoding and a branch helper.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  // 4-bit op codes understood by the Alu
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_SUM   = 4'b0010;
  localparam logic [3:0] ALU_EQUAL = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_XOR   = 4'b1000;
  localparam logic [3:0] ALU_NOR   = 4'b1001;  // reserved, never issued
  localparam logic [3:0] ALU_SUB   = 4'b1010;
  localparam logic [3:0] ALU_GE    = 4'b1100;
  localparam logic [3:0] ALU_GEU   = 4'b1101;
  localparam logic [3:0] ALU_SLT   = 4'b1110;
  localparam logic [3:0] ALU_SLTU  = 4'b1111;

  // Major opcodes accepted by the block
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Branch decision from the Alu zero flag. The Alu produces a non-zero
  // result when the compared condition holds, so "taken" is normally ~zr;
  // BNE reuses EQUAL and therefore inverts the sense.
  function automatic logic branch_taken(input logic is_branch,
                                        input logic invert,
                                        input logic zr);
    logic t;
    t = invert ? zr : ~zr;
    return is_branch & t;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into the Alu op code
// plus operand-select, branch and illegal flags.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_op,
  output logic       use_imm,
  output logic       is_branch,
  output logic       invert_taken,
  output logic       illegal
);

  // Shared R/I arithmetic mapping; alt selects SUB / SRA.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_SUM;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Map instruction fields to Alu control; unknown encodings flag illegal.
  always_comb begin
    alu_op       = ALU_AND;
    use_imm      = 1'b0;
    is_branch    = 1'b0;
    invert_taken = 1'b0;
    illegal      = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_op = arith_op(funct3, funct7b5);
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        if (funct3 == 3'b000) begin
          alu_op = ALU_SUM;
        end else begin
          alu_op = arith_op(funct3, funct7b5);
        end
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_EQUAL;
          3'b001: begin
            alu_op       = ALU_EQUAL;
            invert_taken = 1'b1;
          end
          3'b100:  alu_op = ALU_SLT;
          3'b101:  alu_op = ALU_GE;
          3'b110:  alu_op = ALU_SLTU;
          3'b111:  alu_op = ALU_GEU;
          default: begin
            is_branch = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the combinational Alu: registers decoded
// operands, captures the Alu result one cycle later, resolves branches and
// presents the result over a valid/ready handshake.
// Optional feature macro: ALU_ISSUE_CTRL_PERF_EN (retired/taken counters).
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [6:0]      in_opcode_i,
  input  logic [2:0]      in_funct3_i,
  input  logic            in_funct7b5_i,
  input  logic [XLEN-1:0] in_rs1_i,
  input  logic [XLEN-1:0] in_rs2_i,
  input  logic [XLEN-1:0] in_imm_i,
  output logic [3:0]      ALU_OP_o,
  output logic [XLEN-1:0] ALU_RS1_o,
  output logic [XLEN-1:0] ALU_RS2_o,
  input  logic [XLEN-1:0] ALU_RD_i,
  input  logic            ALU_ZR_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_result_o,
  output logic            out_taken_o,
  output logic            out_illegal_o
`ifdef ALU_ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_issued_o,
  output logic [31:0]     perf_taken_o
`endif
);

  state_t            state_r, state_s;
  logic [3:0]        op_r, op_s;
  logic [XLEN-1:0]   rs1_r, rs1_s, rs2_r, rs2_s, res_r, res_s;
  logic              br_r, br_s, inv_r, inv_s;
  logic              valid_r, valid_s, taken_r, taken_s, ill_r, ill_s;
  logic              load_s;

  logic [3:0]        dec_op_s;
  logic              dec_imm_s, dec_br_s, dec_inv_s, dec_ill_s;

  alu_issue_decode u_decode (
    .opcode       (in_opcode_i),
    .funct3       (in_funct3_i),
    .funct7b5     (in_funct7b5_i),
    .alu_op       (dec_op_s),
    .use_imm      (dec_imm_s),
    .is_branch    (dec_br_s),
    .invert_taken (dec_inv_s),
    .illegal      (dec_ill_s)
  );

  assign in_ready_o    = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready_i);
  assign ALU_OP_o      = op_r;
  assign ALU_RS1_o     = rs1_r;
  assign ALU_RS2_o     = rs2_r;
  assign out_valid_o   = valid_r;
  assign out_result_o  = res_r;
  assign out_taken_o   = taken_r;
  assign out_illegal_o = ill_r;

  // Next-state and next-register values; defaults hold every register.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    rs1_s   = rs1_r;
    rs2_s   = rs2_r;
    br_s    = br_r;
    inv_s   = inv_r;
    res_s   = res_r;
    valid_s = valid_r;
    taken_s = taken_r;
    ill_s   = ill_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: load_s = in_valid_i;
      ST_EXEC: begin
        res_s   = ALU_RD_i;
        taken_s = branch_taken(br_r, inv_r, ALU_ZR_i);
        valid_s = 1'b1;
        state_s = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_i) begin
          valid_s = 1'b0;
          state_s = ST_IDLE;
          load_s  = in_valid_i;
        end else begin
          valid_s = 1'b1;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    // A new instruction overrides the retire path above.
    if (load_s) begin
      if (dec_ill_s) begin
        res_s   = '0;
        taken_s = 1'b0;
        ill_s   = 1'b1;
        valid_s = 1'b1;
        state_s = ST_DONE;
      end else begin
        op_s    = dec_op_s;
        rs1_s   = in_rs1_i;
        rs2_s   = dec_imm_s ? in_imm_i : in_rs2_i;
        br_s    = dec_br_s;
        inv_s   = dec_inv_s;
        ill_s   = 1'b0;
        valid_s = 1'b0;
        state_s = ST_EXEC;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      op_r    <= ALU_AND;
      rs1_r   <= '0;
      rs2_r   <= '0;
      br_r    <= 1'b0;
      inv_r   <= 1'b0;
      res_r   <= '0;
      valid_r <= 1'b0;
      taken_r <= 1'b0;
      ill_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      rs1_r   <= rs1_s;
      rs2_r   <= rs2_s;
      br_r    <= br_s;
      inv_r   <= inv_s;
      res_r   <= res_s;
      valid_r <= valid_s;
      taken_r <= taken_s;
      ill_r   <= ill_s;
    end
  end

`ifdef ALU_ISSUE_CTRL_PERF_EN
  logic [31:0] issued_r, ptaken_r;
  logic        retire_s;

  assign retire_s      = valid_r & out_ready_i;
  assign perf_issued_o = issued_r;
  assign perf_taken_o  = ptaken_r;

  // Count retired legal results and retired taken branches (wrapping).
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      issued_r <= 32'd0;
      ptaken_r <= 32'd0;
    end else begin
      if (retire_s & ~ill_r) begin
        issued_r <= issued_r + 32'd1;
      end else begin
        issued_r <= issued_r;
      end
      if (retire_s & taken_r) begin
        ptaken_r <= ptaken_r + 32'd1;
      end else begin
        ptaken_r <= ptaken_r;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural Alu attached.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1, in_rs2, in_imm;
  logic [3:0]  alu_op;
  logic [31:0] alu_rs1, alu_rs2, alu_rd;
  logic        alu_zr;
  logic        out_valid, out_ready, out_taken, out_illegal;
  logic [31:0] out_result;
`ifdef ALU_ISSUE_CTRL_PERF_EN
  logic [31:0] perf_issued, perf_taken;
  int          exp_issued = 0;
  int          exp_ptaken = 0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        tk;
    logic        ill;
    int          acc;
    int          lat;
    bit          chk;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [3:0]  last_op  = 4'b0000;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl #(.XLEN(32)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_opcode_i   (in_opcode),
    .in_funct3_i   (in_funct3),
    .in_funct7b5_i (in_funct7b5),
    .in_rs1_i      (in_rs1),
    .in_rs2_i      (in_rs2),
    .in_imm_i      (in_imm),
    .ALU_OP_o      (alu_op),
    .ALU_RS1_o     (alu_rs1),
    .ALU_RS2_o     (alu_rs2),
    .ALU_RD_i      (alu_rd),
    .ALU_ZR_i      (alu_zr),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_result_o  (out_result),
    .out_taken_o   (out_taken),
    .out_illegal_o (out_illegal)
`ifdef ALU_ISSUE_CTRL_PERF_EN
    ,
    .perf_issued_o (perf_issued),
    .perf_taken_o  (perf_taken)
`endif
  );

  // Behavioural Alu: compare ops return 1 when the condition holds.
  always_comb begin
    alu_rd = 32'd0;
    case (alu_op)
      4'b0000: alu_rd = alu_rs1 & alu_rs2;
      4'b0001: alu_rd = alu_rs1 | alu_rs2;
      4'b0010: alu_rd = alu_rs1 + alu_rs2;
      4'b0011: alu_rd = {31'd0, alu_rs1 == alu_rs2};
      4'b0100: alu_rd = alu_rs1 << alu_rs2[4:0];
      4'b0101: alu_rd = alu_rs1 >> alu_rs2[4:0];
      4'b0111: alu_rd = $unsigned($signed(alu_rs1) >>> alu_rs2[4:0]);
      4'b1000: alu_rd = alu_rs1 ^ alu_rs2;
      4'b1001: alu_rd = ~(alu_rs1 | alu_rs2);
      4'b1010: alu_rd = alu_rs1 - alu_rs2;
      4'b1100: alu_rd = {31'd0, $signed(alu_rs1) >= $signed(alu_rs2)};
      4'b1101: alu_rd = {31'd0, alu_rs1 >= alu_rs2};
      4'b1110: alu_rd = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
      4'b1111: alu_rd = {31'd0, alu_rs1 < alu_rs2};
      default: alu_rd = 32'd0;
    endcase
    alu_zr = (alu_rd == 32'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one instruction (caller is just after a rising edge), wait for
  // acceptance, push the expectation and check the issued Alu op.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [3:0] exp_op, input logic [31:0] exp_res,
                       input logic exp_tk, input logic exp_ill, input bit chk_lat);
    exp_t e;
    bit   ok;
    in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1 = a; in_rs2 = b; in_imm = imm;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
    end else begin
      e.res = exp_res; e.tk = exp_tk; e.ill = exp_ill;
      e.acc = cyc; e.lat = exp_ill ? 1 : 2; e.chk = chk_lat;
      sb.push_back(e);
      @(posedge clk); #1 in_valid = 1'b0;
      if (exp_ill) begin
        check_eq("alu_op_hold", {28'd0, alu_op}, {28'd0, last_op});
      end else begin
        check_eq("alu_op", {28'd0, alu_op}, {28'd0, exp_op});
        last_op = exp_op;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Retire monitor: pop and compare each handshake-completed result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("result", out_result, mon_e.res);
        check_eq("taken", {31'd0, out_taken}, {31'd0, mon_e.tk});
        check_eq("illegal", {31'd0, out_illegal}, {31'd0, mon_e.ill});
        if (mon_e.chk) check_eq("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
`ifdef ALU_ISSUE_CTRL_PERF_EN
        if (!mon_e.ill) exp_issued++;
        if (mon_e.tk) exp_ptaken++;
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = 7'd0; in_funct3 = 3'd0;
    in_funct7b5 = 1'b0; in_rs1 = 32'd0; in_rs2 = 32'd0; in_imm = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_op", {28'd0, alu_op}, 32'd0);
    check_eq("rst_rs1", alu_rs1, 32'd0);
    check_eq("rst_rs2", alu_rs2, 32'd0);
    check_eq("rst_result", out_result, 32'd0);
    check_eq("rst_flags", {30'd0, out_taken, out_illegal}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // R-type, I-type and branches, issued back to back
    issue(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 4'b1010, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    issue(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 4'b0010, 32'd12, 1'b0, 1'b0, 1'b1);
    issue(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd9, 32'd4, 4'b0111, 32'hF800_0000, 1'b0, 1'b0, 1'b1);
    issue(7'b0010011, 3'b101, 1'b0, 32'h8000_0000, 32'd9, 32'd4, 4'b0101, 32'h0800_0000, 1'b0, 1'b0, 1'b1);
    issue(7'b0010011, 3'b000, 1'b1, 32'd10, 32'd99, 32'hFFFF_FFFF, 4'b0010, 32'd9, 1'b0, 1'b0, 1'b1);
    issue(7'b0110011, 3'b011, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b1111, 32'd1, 1'b0, 1'b0, 1'b1);
    issue(7'b0110011, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1110, 32'd1, 1'b0, 1'b0, 1'b1);
    issue(7'b0110011, 3'b100, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0, 4'b1000, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b1);
    issue(7'b0110011, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 4'b0000, 32'h00F0_00F0, 1'b0, 1'b0, 1'b1);
    issue(7'b0110011, 3'b001, 1'b0, 32'd1, 32'd31, 32'd0, 4'b0100, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    issue(7'b0010011, 3'b110, 1'b0, 32'h0000_00F0, 32'd0, 32'h0000_000F, 4'b0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b1);
    issue(7'b1100011, 3'b000, 1'b0, 32'd3, 32'd3, 32'd0, 4'b0011, 32'd1, 1'b1, 1'b0, 1'b1);
    issue(7'b1100011, 3'b001, 1'b0, 32'd9, 32'd9, 32'd0, 4'b0011, 32'd1, 1'b0, 1'b0, 1'b1);
    issue(7'b1100011, 3'b111, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b1101, 32'd0, 1'b0, 1'b0, 1'b1);
    issue(7'b1100011, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1110, 32'd1, 1'b1, 1'b0, 1'b1);
    issue(7'b1100011, 3'b101, 1'b0, 32'd5, 32'd5, 32'd0, 4'b1100, 32'd1, 1'b1, 1'b0, 1'b1);
    issue(7'b1100011, 3'b110, 1'b0, 32'd2, 32'd1, 32'd0, 4'b1111, 32'd0, 1'b0, 1'b0, 1'b1);
    // Illegal opcodes / funct3, then a legal op clearing the illegal flag
    issue(7'b0000011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 4'b0000, 32'd0, 1'b0, 1'b1, 1'b1);
    issue(7'b1100011, 3'b010, 1'b0, 32'd1, 32'd2, 32'd3, 4'b0000, 32'd0, 1'b0, 1'b1, 1'b1);
    issue(7'b0110011, 3'b000, 1'b0, 32'd20, 32'd22, 32'd0, 4'b0010, 32'd42, 1'b0, 1'b0, 1'b1);
    drain();

    // Backpressure: result held for 5 cycles, then retire + accept together
    out_ready = 1'b0;
    issue(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 4'b1010, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_result", out_result, 32'hFFFF_FFFE);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    issue(7'b0110011, 3'b110, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'd0, 4'b0001, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset while the instruction is in EXEC
    issue(7'b0110011, 3'b100, 1'b0, 32'd6, 32'd3, 32'd0, 4'b1000, 32'd5, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    last_op = 4'b0000;
`ifdef ALU_ISSUE_CTRL_PERF_EN
    check_eq("perf_issued_pre", 32'(exp_issued), 32'd0);
    exp_issued = 0; exp_ptaken = 0;
    check_eq("rst_perf_issued", perf_issued, 32'd0);
    check_eq("rst_perf_taken", perf_taken, 32'd0);
`endif
    check_eq("rst2_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst2_op", {28'd0, alu_op}, 32'd0);
    check_eq("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    issue(7'b1100011, 3'b000, 1'b0, 32'd8, 32'd8, 32'd0, 4'b0011, 32'd1, 1'b1, 1'b0, 1'b1);
    drain();
`ifdef ALU_ISSUE_CTRL_PERF_EN
    check_eq("perf_issued", perf_issued, 32'(exp_issued));
    check_eq("perf_taken", perf_taken, 32'(exp_ptaken));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
